// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the producers/decode stage and regfile_wb_arbiter.
//   master : producers and decode (drive requests, issue info and source checks)
//   slave  : the arbiter (drives grants, the register-file write port and busy flags)
// Signals:
//   req_valid/req_ready/req_rd/req_data    : per-requester write-back handshake
//   reg_write/rd_addr/write_data           : registered register-file write port
//   issue_valid/issue_rd                   : destination of a newly issued instruction
//   chk_rs1_addr/chk_rs2_addr, rs1/2_busy  : RAW hazard lookup for decode
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          reg_write;
   logic [ADDR_WIDTH-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0]         write_data;
   logic                          issue_valid;
   logic [ADDR_WIDTH-1:0]         issue_rd;
   logic [ADDR_WIDTH-1:0]         chk_rs1_addr;
   logic [ADDR_WIDTH-1:0]         chk_rs2_addr;
   logic                          rs1_busy;
   logic                          rs2_busy;

   modport master (
      output req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1_addr, chk_rs2_addr,
      input  req_ready, reg_write, rd_addr, write_data, rs1_busy, rs2_busy
   );

   modport slave (
      input  req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1_addr, chk_rs2_addr,
      output req_ready, reg_write, rd_addr, write_data, rs1_busy, rs2_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for a single-write-port
// register file.
//   - Round-robin grant among NUM_REQ producers, one handshake per cycle.
//   - Winning write is registered onto reg_write/rd_addr/write_data; the
//     register file writes on the following edge. rd=0 writes are accepted
//     but never assert reg_write.
//   - Optional scoreboard (macro REGFILE_WB_SCOREBOARD_EN) tracks destinations
//     issued but not yet written so decode can stall on RAW hazards. Without
//     the macro rs1_busy/rs2_busy are tied low and issue/check inputs ignored.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : regfile_wb_arbiter_if.slave (requests, commit port, scoreboard)
module regfile_wb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic                clk,
   input logic                reset,
   regfile_wb_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      win;
   logic [PTR_W-1:0]      ptr_nxt;
   logic                  any_valid;
   logic                  handshake;
   logic [NUM_REQ-1:0]    ready;

   logic [ADDR_WIDTH-1:0] rd_arr   [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   logic                  commit_we;
   logic [ADDR_WIDTH-1:0] commit_rd;
   logic [DATA_WIDTH-1:0] commit_data;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign rd_arr[g]   = bus.req_rd[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan from the priority pointer upward (wrapping) and take the first valid.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_sel;
      win       = '0;
      any_valid = 1'b0;
      idx       = 0;
      idx_sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_sel = PTR_W'(idx);
         if (!any_valid && bus.req_valid[idx_sel]) begin
            any_valid = 1'b1;
            win       = idx_sel;
         end
      end
   end

   assign handshake = any_valid && !reset;

   always_comb begin
      ready = '0;
      if (handshake) ready[win] = 1'b1;
   end

   assign ptr_nxt = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr         <= '0;
         commit_we   <= 1'b0;
         commit_rd   <= '0;
         commit_data <= '0;
      end else begin
         commit_we <= 1'b0;
         if (handshake) begin
            ptr         <= ptr_nxt;
            commit_we   <= (rd_arr[win] != '0);
            commit_rd   <= rd_arr[win];
            commit_data <= data_arr[win];
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.reg_write  = commit_we;
   assign bus.rd_addr    = commit_rd;
   assign bus.write_data = commit_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   // Clear follows the register-file write; a same-edge issue to the same
   // register must win, so the set is applied after the clear.
   always_comb begin
      busy_nxt = busy;
      if (commit_we) busy_nxt[commit_rd] = 1'b0;
      if (bus.issue_valid) busy_nxt[bus.issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   assign bus.rs1_busy = busy[bus.chk_rs1_addr];
   assign bus.rs2_busy = busy[bus.chk_rs2_addr];
`else
   logic unused_sb;
   assign unused_sb    = ^{bus.issue_valid, bus.issue_rd, bus.chk_rs1_addr, bus.chk_rs2_addr};
   assign bus.rs1_busy = 1'b0;
   assign bus.rs2_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef REGFILE_WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register file fed by the DUT's write port.
   logic [DW-1:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk) if (bus.reg_write && bus.rd_addr != 0) rf[bus.rd_addr] <= bus.write_data;

   // Behavioural model: next-priority index, pending commit, busy set.
   int            m_rr;
   bit            m_we;
   bit [AW-1:0]   m_rd;
   bit [DW-1:0]   m_data;
   bit [31:0]     m_busy;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   initial begin
      m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_busy = '0;
      forever begin
         @(posedge clk);
         begin
            logic [N-1:0] v;
            int w;
            v = bus.req_valid;
            if (reset) begin
               m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_busy = '0;
            end else begin
               if (m_we) m_busy[m_rd] = 1'b0;
               if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
               w = pick(v, m_rr);
               if (w >= 0) begin
                  m_rd   = bus.req_rd[w*AW +: AW];
                  m_data = bus.req_data[w*DW +: DW];
                  m_we   = (m_rd != 0);
                  m_rr   = (w + 1) % N;
               end else begin
                  m_we = 1'b0;
               end
            end
         end
         @(negedge clk);
         begin
            int w;
            logic [N-1:0] er;
            w  = pick(bus.req_valid, m_rr);
            er = '0;
            if (!reset && w >= 0) er[w] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(er));
            check("reg_write", 64'(bus.reg_write), 64'(m_we));
            check("rd_addr", 64'(bus.rd_addr), 64'(m_rd));
            check("write_data", 64'(bus.write_data), 64'(m_data));
            check("rs1_busy", 64'(bus.rs1_busy), 64'(SB & m_busy[bus.chk_rs1_addr]));
            check("rs2_busy", 64'(bus.rs2_busy), 64'(SB & m_busy[bus.chk_rs2_addr]));
         end
      end
   end

   // Requester state driven onto the bus.
   logic [N-1:0]  v;
   logic [AW-1:0] r_rd  [N];
   logic [DW-1:0] r_dat [N];

   task automatic pack();
      bus.req_valid = v;
      for (int i = 0; i < N; i++) begin
         bus.req_rd[i*AW +: AW]   = r_rd[i];
         bus.req_data[i*DW +: DW] = r_dat[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v = '0;
      bus.issue_valid = 1'b0;
      pack();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [N-1:0] hs;
      reset = 1'b1;
      v = '0;
      for (int i = 0; i < N; i++) begin r_rd[i] = '0; r_dat[i] = '0; end
      bus.issue_valid = 1'b0; bus.issue_rd = '0;
      bus.chk_rs1_addr = '0; bus.chk_rs2_addr = '0;
      pack();
      tick(); tick();
      @(negedge clk);
      check("reset reg_write", 64'(bus.reg_write), 64'h0);
      check("reset rd_addr", 64'(bus.rd_addr), 64'h0);
      check("reset write_data", 64'(bus.write_data), 64'h0);
      check("reset req_ready", 64'(bus.req_ready), 64'h0);
      tick();
      reset = 1'b0;

      // Single requester, rd=1
      v = 3'b001; r_rd[0] = 5'd1; r_dat[0] = 32'hA5A5A5A5; pack();
      @(negedge clk);
      check("t1 ready", 64'(bus.req_ready), 64'h1);
      tick(); v = '0; pack();
      @(negedge clk);
      check("t1 reg_write", 64'(bus.reg_write), 64'h1);
      check("t1 rd_addr", 64'(bus.rd_addr), 64'h1);
      check("t1 write_data", 64'(bus.write_data), 64'hA5A5A5A5);
      tick();
      check("t1 x1", 64'(rf[1]), 64'hA5A5A5A5);

      // All three continuously valid
      do_reset();
      v = 3'b111;
      r_rd[0] = 5'd3; r_dat[0] = 32'h33333333;
      r_rd[1] = 5'd4; r_dat[1] = 32'h44444444;
      r_rd[2] = 5'd5; r_dat[2] = 32'h55555555;
      pack();
      for (int c = 0; c < 6; c++) begin
         logic [N-1:0] e;
         e = '0; e[c % N] = 1'b1;
         @(negedge clk);
         check("t2 grant", 64'(bus.req_ready), 64'(e));
         tick();
      end
      v = '0; pack();
      tick();
      check("t2 x3", 64'(rf[3]), 64'h33333333);
      check("t2 x4", 64'(rf[4]), 64'h44444444);
      check("t2 x5", 64'(rf[5]), 64'h55555555);

      // rd=0 request
      do_reset();
      v = 3'b100; r_rd[2] = 5'd0; r_dat[2] = 32'hFFFFFFFF; pack();
      @(negedge clk);
      check("t3 ready", 64'(bus.req_ready), 64'h4);
      tick(); v = '0; pack();
      @(negedge clk);
      check("t3 reg_write", 64'(bus.reg_write), 64'h0);
      tick();
      check("t3 x0", 64'(rf[0]), 64'h0);

      // Scoreboard set/clear around a write to x7
      do_reset();
      bus.chk_rs1_addr = 5'd7; bus.chk_rs2_addr = 5'd0;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
      tick();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      check("t4 rs1 after issue", 64'(bus.rs1_busy), 64'(SB));
      check("t4 rs2 x0", 64'(bus.rs2_busy), 64'h0);
      v = 3'b010; r_rd[1] = 5'd7; r_dat[1] = 32'h12345678; pack();
      @(negedge clk);
      check("t4 ready", 64'(bus.req_ready), 64'h2);
      tick(); v = '0; pack();
      @(negedge clk);
      check("t4 reg_write", 64'(bus.reg_write), 64'h1);
      check("t4 rs1 during commit", 64'(bus.rs1_busy), 64'(SB));
      tick();
      @(negedge clk);
      check("t4 rs1 cleared", 64'(bus.rs1_busy), 64'h0);
      check("t4 x7", 64'(rf[7]), 64'h12345678);

      // Reset with a commit pending
      do_reset();
      bus.chk_rs1_addr = 5'd9;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      v = 3'b011; r_rd[0] = 5'd10; r_dat[0] = 32'hAAAA0010;
      r_rd[1] = 5'd11; r_dat[1] = 32'hBBBB0011; pack();
      tick();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      check("t5 busy before reset", 64'(bus.rs1_busy), 64'(SB));
      check("t5 pending commit", 64'(bus.reg_write), 64'h1);
      reset = 1'b1;
      #1;
      check("t5 ready in reset", 64'(bus.req_ready), 64'h0);
      tick();
      @(negedge clk);
      check("t5 reg_write dropped", 64'(bus.reg_write), 64'h0);
      check("t5 busy cleared", 64'(bus.rs1_busy), 64'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t5 first grant", 64'(bus.req_ready), 64'h1);
      tick();

      // Randomized traffic checked against the model
      hs = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            if (!v[i] || hs[i]) begin
               if (v[i] && $urandom_range(0, 1) == 0) v[i] = 1'b0;
               else if ($urandom_range(0, 2) != 0) begin
                  v[i]     = 1'b1;
                  r_rd[i]  = AW'($urandom_range(0, 31));
                  r_dat[i] = $urandom;
               end else v[i] = 1'b0;
            end
         end
         pack();
         r = $urandom_range(0, 31);
         bus.issue_rd    = AW'(r);
         bus.issue_valid = ($urandom_range(0, 2) == 0) && !m_busy[r];
         bus.chk_rs1_addr = ($urandom_range(0, 1) == 0) ? m_rd : AW'($urandom_range(0, 31));
         bus.chk_rs2_addr = AW'($urandom_range(0, 31));
         @(negedge clk);
         hs = bus.req_valid & bus.req_ready;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
